regfile_wb_writer: RTL and testbench

- Write-side initiator for the 32x32 register file's single write port (WEN/RW/busW).
- Accepts writeback requests from two producers, the ALU and the LSU, over valid/ready handshakes.
- Buffers requests in a small in-order FIFO and issues at most one register-file write per cycle.
- Provides bypass lookup so read-side consumers see values still pending in the writer.

---
 rtl/regfile_wb_writer_if.sv | 65 ++++++
 rtl/regfile_wb_writer.sv | 162 ++++++++++++++++
 tb/tb_regfile_wb_writer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_writer_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_writer_if
//   Bundle of every non-clock/reset signal of regfile_wb_writer.
//
//   Producer side : alu_valid/alu_ready/alu_rd/alu_data,
//                   lsu_valid/lsu_ready/lsu_rd/lsu_data
//   Control       : rf_hold (inhibit a register-file write this cycle)
//   RF write port : WEN, RW, busW (registered)
//   Bypass lookup : RX, RY in; fwdX_hit/fwdX_data, fwdY_hit/fwdY_data out
//   Status        : count (FIFO occupancy, $clog2(DEPTH)+1 bits)
//
//   Modport slave is the writer's view; modport master is the environment's.
// ---------------------------------------------------------------------------
interface regfile_wb_writer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;

  logic          lsu_valid;
  logic          lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;

  logic          rf_hold;

  logic          WEN;
  logic [AW-1:0] RW;
  logic [DW-1:0] busW;

  logic [AW-1:0] RX;
  logic [AW-1:0] RY;
  logic          fwdX_hit;
  logic [DW-1:0] fwdX_data;
  logic          fwdY_hit;
  logic [DW-1:0] fwdY_data;

  logic [CW-1:0] count;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  rf_hold, RX, RY,
    output alu_ready, lsu_ready,
    output WEN, RW, busW,
    output fwdX_hit, fwdX_data, fwdY_hit, fwdY_data,
    output count
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output rf_hold, RX, RY,
    input  alu_ready, lsu_ready,
    input  WEN, RW, busW,
    input  fwdX_hit, fwdX_data, fwdY_hit, fwdY_data,
    input  count
  );
endinterface

// File: rtl/regfile_wb_writer.sv
// ---------------------------------------------------------------------------
// regfile_wb_writer
//   Write-side initiator for the register file's single write port.
//   Accepts writeback requests from the LSU (fixed priority) and the ALU,
//   queues them in an in-order FIFO of DEPTH entries and pops at most one
//   entry per cycle into the registered WEN/RW/busW stage.
//
//   Ports:
//     Clk   - clock, all state updates on posedge
//     rst_n - synchronous active-low reset
//     wb    - regfile_wb_writer_if.slave: producer handshakes, rf_hold,
//             register-file write port, bypass lookup, FIFO count
//
//   Optional feature (macro REGFILE_WB_BYPASS_EN):
//     defined   - combinational bypass lookup for RX/RY over the FIFO
//                 (youngest first) and the output stage
//     undefined - bypass outputs tied to 0
// ---------------------------------------------------------------------------
module regfile_wb_writer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic                 Clk,
  input logic                 rst_n,
  regfile_wb_writer_if.slave  wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage and pointers
  logic [AW-1:0] mem_rd   [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  // Output stage
  logic          wen_q;
  logic [AW-1:0] rw_q;
  logic [DW-1:0] busw_q;

  // Request selection
  logic          space;
  logic          req_fire;
  logic [AW-1:0] req_rd;
  logic [DW-1:0] req_data;
  logic          push_en;
  logic          pop_en;

  // Space is judged on the registered count only, so a pop in the same
  // cycle never opens a slot for a new request.
  assign space        = (count_q < CW'(DEPTH));
  assign wb.lsu_ready = space;
  assign wb.alu_ready = space && !wb.lsu_valid;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    req_fire = 1'b0;
    req_rd   = '0;
    req_data = '0;
    if (wb.lsu_valid && wb.lsu_ready) begin
      req_fire = 1'b1;
      req_rd   = wb.lsu_rd;
      req_data = wb.lsu_data;
    end else if (wb.alu_valid && wb.alu_ready) begin
      req_fire = 1'b1;
      req_rd   = wb.alu_rd;
      req_data = wb.alu_data;
    end
  end

  // Writes to r0 are handshaken but dropped: r0 is hard-wired to zero.
  assign push_en = req_fire && (req_rd != '0);
  assign pop_en  = (count_q != '0) && !wb.rf_hold;

  // NOTE: the FIFO array has no reset; only pointers and count are cleared,
  // and entries outside [rd_ptr, rd_ptr+count) are never observed.
  always_ff @(posedge Clk) begin
    if (push_en) begin
      mem_rd[wr_ptr]   <= req_rd;
      mem_data[wr_ptr] <= req_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      wen_q   <= 1'b0;
      rw_q    <= '0;
      busw_q  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(push_en) - CW'(pop_en);

      wen_q <= pop_en;
      if (pop_en) begin
        rw_q   <= mem_rd[rd_ptr];
        busw_q <= mem_data[rd_ptr];
      end
    end
  end

  assign wb.WEN   = wen_q;
  assign wb.RW    = rw_q;
  assign wb.busW  = busw_q;
  assign wb.count = count_q;

`ifdef REGFILE_WB_BYPASS_EN
  typedef struct packed {
    logic          hit;
    logic [DW-1:0] data;
  } fwd_t;

  // Walk oldest to youngest so the youngest match overwrites older ones;
  // the output stage is older than anything still in the FIFO.
  function automatic fwd_t lookup(input logic [AW-1:0] addr);
    fwd_t          r;
    logic [PW-1:0] idx;
    r = '0;
    if (addr != '0) begin
      if (wen_q && (rw_q == addr)) begin
        r.hit  = 1'b1;
        r.data = busw_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if ((CW'(i) < count_q) && (mem_rd[idx] == addr)) begin
          r.hit  = 1'b1;
          r.data = mem_data[idx];
        end
      end
    end
    return r;
  endfunction

  fwd_t fwd_x;
  fwd_t fwd_y;

  always_comb begin
    fwd_x = lookup(wb.RX);
    fwd_y = lookup(wb.RY);
  end

  assign wb.fwdX_hit  = fwd_x.hit;
  assign wb.fwdX_data = fwd_x.data;
  assign wb.fwdY_hit  = fwd_y.hit;
  assign wb.fwdY_data = fwd_y.data;
`else
  assign wb.fwdX_hit  = 1'b0;
  assign wb.fwdX_data = '0;
  assign wb.fwdY_hit  = 1'b0;
  assign wb.fwdY_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_writer.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_writer
//   Directed bench for regfile_wb_writer. Each table row is one clock cycle:
//   inputs are driven on the falling edge, and outputs are compared 1 ns
//   later. Registered outputs therefore show the result of earlier rising
//   edges; ready and bypass outputs reflect this row's inputs and the
//   current state. Expected bypass values apply when REGFILE_WB_BYPASS_EN is
//   defined, otherwise the bypass outputs must read 0.
// ---------------------------------------------------------------------------
module tb_regfile_wb_writer;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic Clk = 1'b0;
  logic rst_n;

  always #5 Clk = ~Clk;

  regfile_wb_writer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  regfile_wb_writer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk   (Clk),
    .rst_n (rst_n),
    .wb    (bus.slave)
  );

  typedef struct {
    // inputs
    logic          lv;
    logic [AW-1:0] lrd;
    logic [DW-1:0] ldat;
    logic          av;
    logic [AW-1:0] ard;
    logic [DW-1:0] adat;
    logic          hold;
    logic [AW-1:0] rx;
    logic [AW-1:0] ry;
    // expected outputs
    logic          e_lrdy;
    logic          e_ardy;
    logic          e_wen;
    logic [AW-1:0] e_rw;
    logic [DW-1:0] e_busw;
    logic [2:0]    e_cnt;
    logic          e_xhit;
    logic [DW-1:0] e_xdat;
    logic          e_yhit;
    logic [DW-1:0] e_ydat;
  } vec_t;

  vec_t vecs[$];

  int n_applied = 0;
  int n_fail    = 0;

  function automatic vec_t mk(
    input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldat,
    input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
    input logic hold, input logic [AW-1:0] rx, input logic [AW-1:0] ry,
    input logic e_lrdy, input logic e_ardy, input logic e_wen,
    input logic [AW-1:0] e_rw, input logic [DW-1:0] e_busw,
    input logic [2:0] e_cnt,
    input logic e_xhit, input logic [DW-1:0] e_xdat,
    input logic e_yhit, input logic [DW-1:0] e_ydat);
    vec_t v;
    v.lv = lv;  v.lrd = lrd;  v.ldat = ldat;
    v.av = av;  v.ard = ard;  v.adat = adat;
    v.hold = hold; v.rx = rx; v.ry = ry;
    v.e_lrdy = e_lrdy; v.e_ardy = e_ardy; v.e_wen = e_wen;
    v.e_rw = e_rw; v.e_busw = e_busw; v.e_cnt = e_cnt;
    v.e_xhit = e_xhit; v.e_xdat = e_xdat;
    v.e_yhit = e_yhit; v.e_ydat = e_ydat;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.lsu_valid = v.lv;  bus.lsu_rd = v.lrd;  bus.lsu_data = v.ldat;
    bus.alu_valid = v.av;  bus.alu_rd = v.ard;  bus.alu_data = v.adat;
    bus.rf_hold   = v.hold;
    bus.RX        = v.rx;
    bus.RY        = v.ry;
  endtask

  task automatic check_vec(input int k, input vec_t v);
    logic          xh, yh;
    logic [DW-1:0] xd, yd;
`ifdef REGFILE_WB_BYPASS_EN
    xh = v.e_xhit; xd = v.e_xdat; yh = v.e_yhit; yd = v.e_ydat;
`else
    xh = 1'b0; xd = '0; yh = 1'b0; yd = '0;
`endif
    check($sformatf("v%0d lsu_ready", k), 32'(bus.lsu_ready), 32'(v.e_lrdy));
    check($sformatf("v%0d alu_ready", k), 32'(bus.alu_ready), 32'(v.e_ardy));
    check($sformatf("v%0d WEN", k),       32'(bus.WEN),       32'(v.e_wen));
    check($sformatf("v%0d RW", k),        32'(bus.RW),        32'(v.e_rw));
    check($sformatf("v%0d busW", k),      bus.busW,           v.e_busw);
    check($sformatf("v%0d count", k),     32'(bus.count),     32'(v.e_cnt));
    check($sformatf("v%0d fwdX_hit", k),  32'(bus.fwdX_hit),  32'(xh));
    check($sformatf("v%0d fwdX_data", k), bus.fwdX_data,      xd);
    check($sformatf("v%0d fwdY_hit", k),  32'(bus.fwdY_hit),  32'(yh));
    check($sformatf("v%0d fwdY_data", k), bus.fwdY_data,      yd);
  endtask

  initial begin
    //             lv lrd ldat     av ard adat           hd rx ry | lr ar wen rw busw          cnt xh xd            yh yd
    // single ALU write rd=5
    vecs.push_back(mk(0, 0, 0,     1, 5, 32'hDEADBEEF, 0, 5, 0,   1, 1, 0, 0, 0,            0, 0, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            0, 5, 0,   1, 1, 0, 0, 0,            1, 1, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            0, 5, 0,   1, 1, 1, 5, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 0));
    // LSU and ALU together: LSU wins, ALU follows
    vecs.push_back(mk(1, 3, 32'h11, 1, 4, 32'h22,      0, 4, 3,   1, 0, 0, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0,     1, 4, 32'h22,       0, 4, 3,   1, 1, 0, 5, 32'hDEADBEEF, 1, 0, 0,            1, 32'h11));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            0, 4, 3,   1, 1, 1, 3, 32'h11,       1, 1, 32'h22,       1, 32'h11));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            0, 4, 3,   1, 1, 1, 4, 32'h22,       0, 1, 32'h22,       0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            0, 4, 3,   1, 1, 0, 4, 32'h22,       0, 0, 0,            0, 0));
    // hold, fill with LSU rd=1..4, fifth refused until a slot frees
    vecs.push_back(mk(1, 1, 32'h101, 0, 0, 0,          1, 2, 4,   1, 0, 0, 4, 32'h22,       0, 0, 0,            0, 0));
    vecs.push_back(mk(1, 2, 32'h102, 0, 0, 0,          1, 2, 4,   1, 0, 0, 4, 32'h22,       1, 0, 0,            0, 0));
    vecs.push_back(mk(1, 3, 32'h103, 0, 0, 0,          1, 2, 4,   1, 0, 0, 4, 32'h22,       2, 1, 32'h102,      0, 0));
    vecs.push_back(mk(1, 4, 32'h104, 0, 0, 0,          1, 2, 4,   1, 0, 0, 4, 32'h22,       3, 1, 32'h102,      0, 0));
    vecs.push_back(mk(1, 5, 32'h105, 0, 0, 0,          1, 2, 4,   0, 0, 0, 4, 32'h22,       4, 1, 32'h102,      1, 32'h104));
    // release hold: pop happens, but full this cycle so ready stays 0
    vecs.push_back(mk(1, 5, 32'h105, 0, 0, 0,          0, 2, 4,   0, 0, 0, 4, 32'h22,       4, 1, 32'h102,      1, 32'h104));
    vecs.push_back(mk(1, 5, 32'h105, 0, 0, 0,          0, 2, 4,   1, 0, 1, 1, 32'h101,      3, 1, 32'h102,      1, 32'h104));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            0, 2, 4,   1, 1, 1, 2, 32'h102,      3, 1, 32'h102,      1, 32'h104));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            0, 2, 4,   1, 1, 1, 3, 32'h103,      2, 0, 0,            1, 32'h104));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            0, 2, 4,   1, 1, 1, 4, 32'h104,      1, 0, 0,            1, 32'h104));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            0, 2, 4,   1, 1, 1, 5, 32'h105,      0, 0, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            0, 2, 4,   1, 1, 0, 5, 32'h105,      0, 0, 0,            0, 0));
    // same rd twice under hold: youngest wins, RY=0 never hits
    vecs.push_back(mk(0, 0, 0,     1, 7, 32'hA,        1, 7, 0,   1, 1, 0, 5, 32'h105,      0, 0, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0,     1, 7, 32'hB,        1, 7, 0,   1, 1, 0, 5, 32'h105,      1, 1, 32'hA,        0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            1, 7, 0,   1, 1, 0, 5, 32'h105,      2, 1, 32'hB,        0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            0, 7, 0,   1, 1, 0, 5, 32'h105,      2, 1, 32'hB,        0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            0, 7, 0,   1, 1, 1, 7, 32'hA,        1, 1, 32'hB,        0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            0, 7, 0,   1, 1, 1, 7, 32'hB,        0, 1, 32'hB,        0, 0));
    // rd=0 requests: accepted, never enqueued or written
    vecs.push_back(mk(0, 0, 0,     1, 0, 32'h55,       0, 0, 0,   1, 1, 0, 7, 32'hB,        0, 0, 0,            0, 0));
    vecs.push_back(mk(1, 0, 32'h77, 0, 0, 0,           0, 0, 0,   1, 0, 0, 7, 32'hB,        0, 0, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            0, 0, 0,   1, 1, 0, 7, 32'hB,        0, 0, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,            0, 0, 0,   1, 1, 0, 7, 32'hB,        0, 0, 0,            0, 0));

    // reset
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge Clk);
      drive(vecs[k]);
      #1;
      check_vec(k, vecs[k]);
    end

    // Reset in the middle of traffic: three entries queued under hold,
    // one popped, then reset with a request still being offered.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      bus.rf_hold   = 1'b1;
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = AW'(9 + i);
      bus.lsu_data  = 32'h900 + DW'(i);
    end
    @(negedge Clk);
    bus.lsu_valid = 1'b0;
    bus.rf_hold   = 1'b0;
    #1;
    check("rst pre count", 32'(bus.count), 32'd3);
    @(negedge Clk);
    #1;
    check("rst pre WEN",   32'(bus.WEN),   32'd1);
    check("rst pre RW",    32'(bus.RW),    32'd9);
    check("rst pre count2", 32'(bus.count), 32'd2);
    rst_n         = 1'b0;
    bus.lsu_valid = 1'b1;
    bus.lsu_rd    = 5'd12;
    bus.lsu_data  = 32'hC00;
    @(negedge Clk);
    rst_n         = 1'b1;
    bus.lsu_valid = 1'b0;
    #1;
    check("rst count",     32'(bus.count),     32'd0);
    check("rst WEN",       32'(bus.WEN),       32'd0);
    check("rst RW",        32'(bus.RW),        32'd0);
    check("rst busW",      bus.busW,           32'd0);
    check("rst lsu_ready", 32'(bus.lsu_ready), 32'd1);
    check("rst alu_ready", 32'(bus.alu_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      #1;
      check($sformatf("post-rst%0d WEN", i),   32'(bus.WEN),   32'd0);
      check($sformatf("post-rst%0d count", i), 32'(bus.count), 32'd0);
      check($sformatf("post-rst%0d fwdX", i),  32'(bus.fwdX_hit), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule
